// File: rtl/lc3b_types.sv
// lc3b_types: shared word/fetch-state types and prefetch queue sizing for the LC-3b front end.
// Build option IF_PREFETCH_QUEUE_EN: defined -> 2-entry prefetch queue, undefined -> 1-entry buffer.
// Types and constants only; no logic, no latency.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } lc3b_fetch_state;

`ifdef IF_PREFETCH_QUEUE_EN
    localparam int FQ_DEPTH = 2;
`else
    localparam int FQ_DEPTH = 1;
`endif

    localparam int FQ_CNT_W = $clog2(FQ_DEPTH + 1);
    localparam logic [FQ_CNT_W-1:0] FQ_DEPTH_C = FQ_DEPTH[FQ_CNT_W-1:0];

    // Sequential instruction address; wraps naturally at 16'hFFFE -> 16'h0000.
    function automatic lc3b_word pc_next(input lc3b_word pc);
        return pc + 16'd2;
    endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: in-order instruction/PC buffer; entry 0 is always the head, so head outputs come straight from flops.
// Latency: a push is visible at the head the cycle after it is written into an empty queue.
// Backpressure: caller must not push when full; flush beats push/pop; pop on empty is ignored.
module if_fetch_queue
    import lc3b_types::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  lc3b_word         push_instr_i,
    input  lc3b_word         push_pc_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output lc3b_word         head_instr_o,
    output lc3b_word         head_pc_o,
    output logic             head_vld_o,
    output logic [CNT_W-1:0] count_o
);

    lc3b_word         instr_q [DEPTH];
    lc3b_word         instr_d [DEPTH];
    lc3b_word         pc_q    [DEPTH];
    lc3b_word         pc_d    [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] wr_idx;
    logic             pop_ok;

    // Shift toward the head on pop, then drop a push into the first free slot after the shift.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        count_d = count_q;
        pop_ok  = pop_i && (count_q != '0);
        wr_idx  = pop_ok ? (count_q - CNT_W'(1)) : count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            if (pop_ok) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    instr_d[i] = instr_q[i+1];
                    pc_d[i]    = pc_q[i+1];
                end
            end
            if (push_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (wr_idx == CNT_W'(i)) begin
                        instr_d[i] = push_instr_i;
                        pc_d[i]    = push_pc_i;
                    end
                end
            end
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_ok);
        end
    end

    // Storage and occupancy registers; contents cleared on reset so the head reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
            count_q <= '0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    assign head_instr_o = instr_q[0];
    assign head_pc_o    = pc_q[0];
    assign head_vld_o   = (count_q != '0);
    assign count_o      = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: LC-3b instruction fetch FSM feeding a prefetch queue (depth set by IF_PREFETCH_QUEUE_EN).
// Latency: mem_resp in cycle N makes the word visible on instr/instr_valid in cycle N+1 when the queue is empty.
// Backpressure: fetches only start while the queue has room; instr_ready pops the head; redirect flushes and wins over pop.
module if_fetch_unit
    import lc3b_types::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000
) (
    input  logic     clk,
    input  logic     rst_n,
    output logic     mem_read,
    output lc3b_word mem_address,
    input  lc3b_word mem_rdata,
    input  logic     mem_resp,
    input  logic     redirect,
    input  lc3b_word redirect_pc,
    output lc3b_word instr,
    output lc3b_word instr_pc,
    output logic     instr_valid,
    input  logic     instr_ready
);

    lc3b_fetch_state      state_q;
    lc3b_fetch_state      state_d;
    lc3b_word             fetch_pc_q;
    lc3b_word             fetch_pc_d;
    lc3b_word             disc_addr_q;
    lc3b_word             disc_addr_d;
    logic                 push;
    logic                 pop;
    logic [FQ_CNT_W-1:0]  q_count;

    // Fetch sequencing: a redirect always retargets fetch_pc; a redirect during an open request
    // either drops the coincident response or parks in DISCARD until the stale response returns.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        disc_addr_d = disc_addr_q;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end else if (q_count < FQ_DEPTH_C) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                    if (mem_resp) begin
                        state_d = IDLE;
                    end else begin
                        state_d     = DISCARD;
                        disc_addr_d = fetch_pc_q;
                    end
                end else if (mem_resp) begin
                    push       = 1'b1;
                    fetch_pc_d = pc_next(fetch_pc_q);
                    state_d    = IDLE;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc;
                end
                if (mem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and address registers; reset abandons any open request outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            disc_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            disc_addr_q <= disc_addr_d;
        end
    end

    assign mem_read    = (state_q == REQ) || (state_q == DISCARD);
    assign mem_address = (state_q == DISCARD) ? disc_addr_q : fetch_pc_q;
    assign pop         = instr_valid && instr_ready && !redirect;

    if_fetch_queue #(
        .DEPTH (FQ_DEPTH),
        .CNT_W (FQ_CNT_W)
    ) u_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .push_instr_i (mem_rdata),
        .push_pc_i    (pc_next(fetch_pc_q)),
        .pop_i        (pop),
        .flush_i      (redirect),
        .head_instr_o (instr),
        .head_pc_o    (instr_pc),
        .head_vld_o   (instr_valid),
        .count_o      (q_count)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed bench for if_fetch_unit (RESET_PC 3000 instance plus a wrap-around FFFE instance).
// Inputs driven #1 after the rising edge, outputs sampled at the same point.
// Expected values are hand-derived constants per scenario.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        mem_read;
    logic [15:0] mem_address;
    logic [15:0] mem_rdata = '0;
    logic        mem_resp = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b1;

    logic        w_mem_read;
    logic [15:0] w_mem_address;
    logic [15:0] w_mem_rdata = '0;
    logic        w_mem_resp = 1'b0;
    logic [15:0] w_instr;
    logic [15:0] w_instr_pc;
    logic        w_instr_valid;
    logic        w_instr_ready = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(16'h3000)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_read    (mem_read),
        .mem_address (mem_address),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    if_fetch_unit #(.RESET_PC(16'hFFFE)) u_dut_w (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_read    (w_mem_read),
        .mem_address (w_mem_address),
        .mem_rdata   (w_mem_rdata),
        .mem_resp    (w_mem_resp),
        .redirect    (1'b0),
        .redirect_pc (16'h0000),
        .instr       (w_instr),
        .instr_pc    (w_instr_pc),
        .instr_valid (w_instr_valid),
        .instr_ready (w_instr_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        mem_resp    = 1'b0;
        mem_rdata   = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        w_mem_resp  = 1'b0;
        #1;
        check_eq("rst_mem_read", mem_read, 1'b0);
        check_eq("rst_valid", instr_valid, 1'b0);
        tick();
        tick();
        check_eq("rst_instr", instr, 16'h0000);
        check_eq("rst_instr_pc", instr_pc, 16'h0000);
        rst_n = 1'b1;
        tick();
        check_eq("rst_first_rd", mem_read, 1'b1);
        check_eq("rst_first_addr", mem_address, 16'h3000);
    endtask

    task automatic wait_read(input string tag, input logic [15:0] exp_addr);
        int n;
        n = 0;
        while (!mem_read && n < 8) begin
            tick();
            n++;
        end
        check_eq({tag, "_rd"}, mem_read, 1'b1);
        check_eq({tag, "_addr"}, mem_address, exp_addr);
    endtask

    // Read held one cycle, then answered with a one-cycle mem_resp.
    task automatic serve(input string tag, input logic [15:0] exp_addr, input logic [15:0] data);
        wait_read(tag, exp_addr);
        tick();
        check_eq({tag, "_hold"}, {15'd0, mem_read, mem_address}, {15'd0, 1'b1, exp_addr});
        mem_resp  = 1'b1;
        mem_rdata = data;
        tick();
        mem_resp  = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic chk_head(input string tag, input logic [15:0] exp_instr, input logic [15:0] exp_pc);
        check_eq({tag, "_vld"}, instr_valid, 1'b1);
        check_eq({tag, "_instr"}, instr, exp_instr);
        check_eq({tag, "_pc"}, instr_pc, exp_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        // Sequential fetch with a always-ready decoder.
        do_reset();
        instr_ready = 1'b1;
        serve("t1_f0", 16'h3000, 16'hA000);
        chk_head("t1_h0", 16'hA000, 16'h3002);
        serve("t1_f1", 16'h3002, 16'hA002);
        chk_head("t1_h1", 16'hA002, 16'h3004);
        serve("t1_f2", 16'h3004, 16'hA004);
        chk_head("t1_h2", 16'hA004, 16'h3006);

        // Decode stall: queue fills, fetching stops, nothing lost on release.
        do_reset();
        instr_ready = 1'b0;
        serve("t2_f0", 16'h3000, 16'h1234);
        chk_head("t2_h0", 16'h1234, 16'h3002);
`ifdef IF_PREFETCH_QUEUE_EN
        serve("t2_f1", 16'h3002, 16'h5678);
        chk_head("t2_h0b", 16'h1234, 16'h3002);
`endif
        repeat (4) tick();
        check_eq("t2_stall_rd", mem_read, 1'b0);
        chk_head("t2_h0c", 16'h1234, 16'h3002);
        instr_ready = 1'b1;
        tick();
`ifdef IF_PREFETCH_QUEUE_EN
        chk_head("t2_h1", 16'h5678, 16'h3004);
        tick();
`endif
        check_eq("t2_empty", instr_valid, 1'b0);

        // Redirect while a read at 3004 is outstanding.
        do_reset();
        serve("t3_f0", 16'h3000, 16'hB000);
        serve("t3_f1", 16'h3002, 16'hB002);
        wait_read("t3_f2", 16'h3004);
        tick();
        redirect    = 1'b1;
        redirect_pc = 16'h4000;
        tick();
        redirect    = 1'b0;
        check_eq("t3_disc_rd", mem_read, 1'b1);
        check_eq("t3_disc_addr", mem_address, 16'h3004);
        check_eq("t3_disc_vld", instr_valid, 1'b0);
        tick();
        check_eq("t3_disc_addr2", mem_address, 16'h3004);
        mem_resp  = 1'b1;
        mem_rdata = 16'hDEAD;
        tick();
        mem_resp  = 1'b0;
        mem_rdata = '0;
        check_eq("t3_drop_vld", instr_valid, 1'b0);
        check_eq("t3_drop_rd", mem_read, 1'b0);
        serve("t3_n", 16'h4000, 16'hC000);
        chk_head("t3_h", 16'hC000, 16'h4002);

        // Redirect coinciding with mem_resp.
        wait_read("t4_f", 16'h4002);
        tick();
        redirect    = 1'b1;
        redirect_pc = 16'h5000;
        mem_resp    = 1'b1;
        mem_rdata   = 16'hBEEF;
        tick();
        redirect  = 1'b0;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        check_eq("t4_drop_vld", instr_valid, 1'b0);
        check_eq("t4_drop_rd", mem_read, 1'b0);
        serve("t4_n", 16'h5000, 16'h1111);
        chk_head("t4_h", 16'h1111, 16'h5002);

        // Redirect beats a same-cycle pop and flushes the head.
        redirect    = 1'b1;
        redirect_pc = 16'h6000;
        tick();
        redirect = 1'b0;
        check_eq("t4_flush_vld", instr_valid, 1'b0);
        wait_read("t4_r", 16'h6000);

        // Address wrap from FFFE to 0000.
        do_reset();
        check_eq("t5_rd0", w_mem_read, 1'b1);
        check_eq("t5_addr0", w_mem_address, 16'hFFFE);
        tick();
        w_mem_resp  = 1'b1;
        w_mem_rdata = 16'h0101;
        tick();
        w_mem_resp  = 1'b0;
        check_eq("t5_vld0", w_instr_valid, 1'b1);
        check_eq("t5_instr0", w_instr, 16'h0101);
        check_eq("t5_pc0", w_instr_pc, 16'h0000);
        n = 0;
        while (!w_mem_read && n < 8) begin
            tick();
            n++;
        end
        check_eq("t5_rd1", w_mem_read, 1'b1);
        check_eq("t5_addr1", w_mem_address, 16'h0000);
        tick();
        w_mem_resp  = 1'b1;
        w_mem_rdata = 16'h0202;
        tick();
        w_mem_resp  = 1'b0;
        check_eq("t5_instr1", w_instr, 16'h0202);
        check_eq("t5_pc1", w_instr_pc, 16'h0002);

        // Asynchronous reset with a valid head, then in the middle of a request.
        do_reset();
        instr_ready = 1'b0;
        serve("t6_f0", 16'h3000, 16'h7777);
        chk_head("t6_h", 16'h7777, 16'h3002);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_vld", instr_valid, 1'b0);
        check_eq("t6_async_instr", instr, 16'h0000);
        check_eq("t6_async_pc", instr_pc, 16'h0000);
        instr_ready = 1'b1;
        do_reset();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_rd", mem_read, 1'b0);
        do_reset();
        serve("t6_restart", 16'h3000, 16'h8888);
        chk_head("t6_rh", 16'h8888, 16'h3002);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 16'h0000, first fetch address after reset.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: mem_read  output  1  instruction memory read request.
REQ-005 SHALL have port: mem_address  output  16  fetch address (lc3b_word).
REQ-006 SHALL have port: mem_rdata  input  16  returned instruction word.
REQ-007 SHALL have port: mem_resp  input  1  one-cycle read-complete strobe.
REQ-008 SHALL have port: redirect  input  1  branch/jump redirect strobe.
REQ-009 SHALL have port: redirect_pc  input  16  redirect target.
REQ-010 SHALL have port: instr  output  16  head instruction to the IR/decode register.
REQ-011 SHALL have port: instr_pc  output  16  head instruction address + 2.
REQ-012 SHALL have port: instr_valid  output  1  head entry valid.
REQ-013 SHALL have port: instr_ready  input  1  downstream accepts head (drives IR load).

Function
REQ-014 SHALL implement FSM states IDLE, REQ, DISCARD.
REQ-015 SHALL assert mem_read only in REQ and DISCARD, mem_address = registered fetch_pc (REQ) or in-flight address (DISCARD), both held stable until mem_resp.
REQ-016 SHALL move IDLE->REQ when queue count < DEPTH and no redirect this cycle.
REQ-017 SHALL, on mem_resp in REQ without redirect, push {mem_rdata, fetch_pc+2}, set fetch_pc += 2 (mod 2^16, 16'hFFFE -> 16'h0000), go IDLE.
REQ-018 SHALL pop head when instr_valid && instr_ready; simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-019 SHALL present instr/instr_pc/instr_valid from registers; mem_resp in cycle N with empty queue -> instr_valid=1 in cycle N+1.
REQ-020 SHALL, on redirect, flush the queue (instr_valid=0 next cycle) and load fetch_pc <= redirect_pc.
REQ-021 SHALL, on redirect while in REQ without mem_resp, go DISCARD; in DISCARD mem_resp data SHALL be dropped and state -> IDLE.
REQ-022 SHALL, on redirect coinciding with mem_resp, drop the response and go IDLE.
REQ-023 SHALL treat a further redirect during DISCARD as updating fetch_pc only.
REQ-024 SHALL never push when full (guaranteed by REQ-016; count only falls during REQ).
REQ-025 SHALL give redirect priority over pop in the same cycle.

Reset
REQ-026 SHALL, on rst_n low, immediately clear mem_read=0, instr_valid=0, count=0, state=IDLE, fetch_pc=RESET_PC, instr=16'h0000, instr_pc=16'h0000.
REQ-027 SHALL abandon any in-flight request on reset without entering DISCARD; first mem_read asserted in the first cycle after the first clk edge following rst_n release.

Configuration
REQ-028 SHALL, with IF_PREFETCH_QUEUE_EN defined, use a 2-entry queue (DEPTH=2) allowing fetch ahead while decode stalls.
REQ-029 SHALL, without IF_PREFETCH_QUEUE_EN, use a single-entry buffer (DEPTH=1); all other behaviour identical.

Structure
REQ-030 SHALL place lc3b_word and the fetch state enum (lc3b_fetch_state) in lc3b_types; RESET_PC stays a module parameter.
REQ-031 SHALL implement the queue as sub-module if_fetch_queue (push, pop, flush, head, count).

Verification
REQ-032 Reset, RESET_PC=16'h3000, mem_resp one cycle after each read, instr_ready=1 -> mem_address 3000, 3002, 3004; instr_pc 3002, 3004, 3006 in order.
REQ-033 instr_ready=0, data 16'h1234/16'h5678 -> with macro two fetches then mem_read=0; without macro one fetch then mem_read=0; no entry lost on release.
REQ-034 Redirect to 16'h4000 while mem_read pending at 3004 -> address held at 3004 until mem_resp, data dropped, next mem_address 4000, queue empty meanwhile.
REQ-035 Redirect to 16'h5000 in same cycle as mem_resp -> response not pushed, next mem_address 5000.
REQ-036 RESET_PC=16'hFFFE -> fetch FFFE then 0000, instr_pc 0000 then 0002.
REQ-037 rst_n low mid-request -> mem_read=0 and instr_valid=0 asynchronously; after release fetch restarts at RESET_PC.
